traffic_phase_ctrl: RTL and testbench

- Sequences the two-way intersection and drives the 7-segment countdown datapath (count, LR1, eLED01, eLED23) and the lamp outputs for both sides.
- A clock prescaler produces a 1 s tick. A phase FSM alternates red between side 1 and side 2, with a yellow interval on the green side before each swap.
- A night input forces flashing yellow on both sides with the displays blanked.

---
 rtl/traffic_phase_ctrl.sv | 169 ++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
// Two-way intersection phase sequencer with 1 s prescaler, countdown datapath and night flashing mode.
// All outputs registered; state, count and lamps update the cycle after tick, no backpressure.
module traffic_phase_ctrl #(
  parameter int TICK_DIV = 50000000,
  parameter int RED_TIME = 45,
  parameter int YEL_TIME = 5,
  parameter int CW       = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          night,
  output logic          tick,
  output logic [CW-1:0] count,
  output logic          LR1,
  output logic          eLED01,
  output logic          eLED23,
  output logic          r1,
  output logic          y1,
  output logic          g1,
  output logic          r2,
  output logic          y2,
  output logic          g2
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);
  localparam logic [CW-1:0] RED_LAST = CW'(RED_TIME - 1);
  localparam logic [CW-1:0] YEL_CNT  = CW'(YEL_TIME);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = '0;

  typedef enum logic [2:0] {S1_GO, S1_YEL, S2_GO, S2_YEL, NIGHT} state_t;

  state_t        state, state_nx;
  logic [PW-1:0] presc;
  logic [CW-1:0] count_nx;
  logic          blink, blink_nx;
  logic          lr1_nx, e01_nx, e23_nx;
  logic          r1_nx, y1_nx, g1_nx, r2_nx, y2_nx, g2_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      tick  <= 1'b0;
    end else begin
      presc <= (presc == PRE_LAST) ? '0 : presc + PRE_ONE;
      tick  <= (presc == PRE_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S1_GO;
      count  <= RED_LAST;
      blink  <= 1'b0;
      LR1    <= 1'b1;
      eLED01 <= 1'b1;
      eLED23 <= 1'b1;
      r1     <= 1'b1;
      y1     <= 1'b0;
      g1     <= 1'b0;
      r2     <= 1'b0;
      y2     <= 1'b0;
      g2     <= 1'b1;
    end else begin
      state  <= state_nx;
      count  <= count_nx;
      blink  <= blink_nx;
      LR1    <= lr1_nx;
      eLED01 <= e01_nx;
      eLED23 <= e23_nx;
      r1     <= r1_nx;
      y1     <= y1_nx;
      g1     <= g1_nx;
      r2     <= r2_nx;
      y2     <= y2_nx;
      g2     <= g2_nx;
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    blink_nx = blink;
    if (tick) begin
      if (night && state != NIGHT) begin
        // Night preempts any phase; the running countdown is dropped.
        state_nx = NIGHT;
        blink_nx = 1'b1;
        count_nx = CNT_ZERO;
      end else begin
        case (state)
          NIGHT: begin
            if (night) begin
              blink_nx = ~blink;
            end else begin
              state_nx = S1_GO;
              count_nx = RED_LAST;
              blink_nx = 1'b0;
            end
          end
          S1_GO: begin
            count_nx = count - CNT_ONE;
            if (count == YEL_CNT) state_nx = S1_YEL;
          end
          S2_GO: begin
            count_nx = count - CNT_ONE;
            if (count == YEL_CNT) state_nx = S2_YEL;
          end
          S1_YEL: begin
            if (count == CNT_ZERO) begin
              state_nx = S2_GO;
              count_nx = RED_LAST;
            end else begin
              count_nx = count - CNT_ONE;
            end
          end
          S2_YEL: begin
            if (count == CNT_ZERO) begin
              state_nx = S1_GO;
              count_nx = RED_LAST;
            end else begin
              count_nx = count - CNT_ONE;
            end
          end
          default: begin
            state_nx = S1_GO;
            count_nx = RED_LAST;
          end
        endcase
      end
    end
  end

  // Lamps and display enables are decoded from the next state so they move with it.
  always_comb begin
    lr1_nx = LR1;
    e01_nx = 1'b0;
    e23_nx = 1'b0;
    r1_nx  = 1'b0;
    y1_nx  = 1'b0;
    g1_nx  = 1'b0;
    r2_nx  = 1'b0;
    y2_nx  = 1'b0;
    g2_nx  = 1'b0;
    case (state_nx)
      S1_GO: begin
        lr1_nx = 1'b1; e01_nx = 1'b1; e23_nx = 1'b1; r1_nx = 1'b1; g2_nx = 1'b1;
      end
      S1_YEL: begin
        lr1_nx = 1'b1; e01_nx = 1'b1; r1_nx = 1'b1; y2_nx = 1'b1;
      end
      S2_GO: begin
        lr1_nx = 1'b0; e01_nx = 1'b1; e23_nx = 1'b1; r2_nx = 1'b1; g1_nx = 1'b1;
      end
      S2_YEL: begin
        lr1_nx = 1'b0; e23_nx = 1'b1; r2_nx = 1'b1; y1_nx = 1'b1;
      end
      NIGHT: begin
        y1_nx = blink_nx; y2_nx = blink_nx;
      end
      default: begin
        lr1_nx = LR1;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: directed phase walk, night mode, mid-phase reset, random night toggling.
// A phase-level model (red side + seconds left) is compared against every output every cycle.
module tb_traffic_phase_ctrl;

  localparam int TD = 4;
  localparam int RT = 45;
  localparam int YT = 5;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          night = 1'b0;
  logic          tick;
  logic [CW-1:0] count;
  logic          LR1, eLED01, eLED23;
  logic          r1, y1, g1, r2, y2, g2;

  traffic_phase_ctrl #(.TICK_DIV(TD), .RED_TIME(RT), .YEL_TIME(YT), .CW(CW)) dut (
    .clk(clk), .rst(rst), .night(night), .tick(tick), .count(count), .LR1(LR1),
    .eLED01(eLED01), .eLED23(eLED23),
    .r1(r1), .y1(y1), .g1(g1), .r2(r2), .y2(y2), .g2(g2)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: which side is red, seconds left in the red phase, night mode and blink phase.
  int m_presc, m_cnt;
  bit m_tick, m_nm, m_lr, m_blink;
  bit m_ok = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_presc = 0; m_tick = 0; m_nm = 0; m_lr = 1; m_cnt = RT - 1; m_blink = 0; m_ok = 1;
    end else begin
      if (m_tick) begin
        if (night && !m_nm) begin
          m_nm = 1; m_blink = 1; m_cnt = 0;
        end else if (m_nm) begin
          if (night) m_blink = !m_blink;
          else begin m_nm = 0; m_lr = 1; m_cnt = RT - 1; end
        end else if (m_cnt == 0) begin
          m_lr = !m_lr; m_cnt = RT - 1;
        end else begin
          m_cnt = m_cnt - 1;
        end
      end
      m_tick  = (m_presc == TD - 1);
      m_presc = (m_presc + 1) % TD;
    end
  end

  always @(posedge clk) begin
    logic [15:0] exp_v, act_v;
    logic er1, ey1, eg1, er2, ey2, eg2, ee1, ee2, yel;
    logic [CW-1:0] ecnt;
    #1;
    if (m_ok) begin
      yel = (m_cnt < YT);
      if (m_nm) begin
        er1 = 0; eg1 = 0; er2 = 0; eg2 = 0; ey1 = m_blink; ey2 = m_blink;
        ee1 = 0; ee2 = 0; ecnt = '0;
      end else begin
        ecnt = CW'(m_cnt);
        er1 = m_lr;  er2 = !m_lr;
        ey1 = !m_lr && yel;  eg1 = !m_lr && !yel;
        ey2 = m_lr && yel;   eg2 = m_lr && !yel;
        ee1 = m_lr || !yel;  ee2 = !m_lr || !yel;
      end
      exp_v = {m_tick, ecnt, m_lr, ee1, ee2, er1, ey1, eg1, er2, ey2, eg2};
      act_v = {tick, count, LR1, eLED01, eLED23, r1, y1, g1, r2, y2, g2};
      chk("cycle_outputs", 32'(act_v), 32'(exp_v));
      chk("lamp_invariant",
          32'((int'(r1) + int'(y1) + int'(g1) > 1) || (int'(r2) + int'(y2) + int'(g2) > 1) || (g1 && g2)),
          32'd0);
      chk("count_range", 32'(count <= CW'(RT - 1)), 32'd1);
    end
  end

  // Waits for the next DUT tick, then one more edge so the update is visible.
  task automatic next_update();
    bit seen = 0;
    for (int i = 0; i < 2 * TD && !seen; i++) begin
      @(posedge clk); #2;
      if (tick === 1'b1) seen = 1;
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL tick_timeout at %0t: got no tick, expected one within %0d cycles", $time, 2 * TD);
    end
    @(posedge clk); #2;
  endtask

  task automatic updates(input int n);
    for (int i = 0; i < n; i++) next_update();
  endtask

  initial begin
    rst = 1; night = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_count", count, 44);
    chk("reset_lr1", LR1, 1);
    chk("reset_lamps", {r1, y1, g1, r2, y2, g2}, 6'b100001);
    chk("reset_tick", tick, 0);
    chk("reset_eled", {eLED01, eLED23}, 2'b11);
    rst = 0;

    next_update();
    chk("first_tick_count", count, 43);
    updates(38);
    chk("s1go_at5_count", count, 5);
    chk("s1go_at5_g2", g2, 1);
    next_update();
    chk("s1yel_count", count, 4);
    chk("s1yel_lamps", {r1, y1, g1, r2, y2, g2}, 6'b100010);
    chk("s1yel_eled", {eLED01, eLED23}, 2'b10);
    updates(4);
    chk("s1yel_zero", count, 0);
    next_update();
    chk("s2go_count", count, 44);
    chk("s2go_lr1", LR1, 0);
    chk("s2go_lamps", {r1, y1, g1, r2, y2, g2}, 6'b001100);
    chk("s2go_eled", {eLED01, eLED23}, 2'b11);
    updates(45);
    chk("cycle90_count", count, 44);
    chk("cycle90_lr1", LR1, 1);

    updates(45);
    updates(14);
    chk("s2go_at30", {LR1, count}, {1'b0, 6'd30});
    night = 1;
    next_update();
    chk("night_entry", {count, r1, y1, g1, r2, y2, g2}, {6'd0, 6'b010010});
    chk("night_eled", {eLED01, eLED23}, 2'b00);
    chk("night_lr1_hold", LR1, 0);
    next_update();
    chk("night_blink1", {y1, y2}, 2'b00);
    next_update();
    chk("night_blink2", {y1, y2}, 2'b11);
    next_update();
    chk("night_blink3", {y1, y2}, 2'b00);
    night = 0;
    next_update();
    chk("night_exit", {LR1, count, r1, g2}, {1'b1, 6'd44, 2'b11});

    updates(45);
    updates(42);
    chk("s2yel_at2", {LR1, count, y1, r2}, {1'b0, 6'd2, 2'b11});
    rst = 1;
    @(posedge clk); #2;
    chk("midrst_count", count, 44);
    chk("midrst_lamps", {LR1, r1, y1, g1, r2, y2, g2}, 7'b1100001);
    chk("midrst_tick", tick, 0);
    rst = 0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #2;
      chk("post_rst_tick", tick, (i == 4) ? 1 : 0);
    end

    // Random night toggling, including sub-tick pulses.
    for (int i = 0; i < 1000 * TD; i++) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 19) == 0) night = !night;
    end
    night = 0;
    repeat (3 * TD) @(posedge clk);
    #3;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
